// File: rtl/ray_generator.sv
// rtl/ray_generator.sv - raster-scanning primary-ray source with AXI-stream output
// Fixed-point incremental stepping of x/y per pixel; single-shot or continuous frames.
module ray_generator #(
    parameter int W       = 32,
    parameter int FRAC    = 16,
    parameter int H_RES   = 1024,
    parameter int V_RES   = 768,
    parameter int X_START = -87381,
    parameter int X_STEP  = 171,
    parameter int Y_START = 65536,
    parameter int Y_STEP  = -171,
    parameter int Z_DIR   = -65536,
    localparam int HW     = $clog2(H_RES),
    localparam int VW     = $clog2(V_RES)
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  start,
    input  logic                  continuous,
    input  logic                  abort,
    output logic                  busy,
    output logic                  frame_done,
    output logic [3*W-1:0]        ray_axis_tdata,
    output logic [HW+VW:0]        ray_axis_tuser,
    output logic                  ray_axis_tlast,
    output logic                  ray_axis_tvalid,
    input  logic                  ray_axis_tready
);

    if (H_RES < 2 || V_RES < 2 || FRAC >= W) begin : g_bad_params
        $error("ray_generator: invalid parameter set");
    end

    localparam logic [W-1:0]  XS     = W'(X_START);
    localparam logic [W-1:0]  XST    = W'(X_STEP);
    localparam logic [W-1:0]  YS     = W'(Y_START);
    localparam logic [W-1:0]  YST    = W'(Y_STEP);
    localparam logic [W-1:0]  ZD     = W'(Z_DIR);
    localparam logic [HW-1:0] H_LAST = HW'(H_RES - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_RES - 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [W-1:0]  x_q, x_d;
    logic [W-1:0]  y_q, y_d;
    logic          tvalid_q, tvalid_d;
    logic          tlast_q, tlast_d;
    logic          sof_q, sof_d;
    logic          done_q, done_d;
    logic          at_eol, at_eof;

    assign at_eol = (h_q == H_LAST);
    assign at_eof = at_eol && (v_q == V_LAST);

    always_comb begin
        state_d  = state_q;
        h_d      = h_q;
        v_d      = v_q;
        x_d      = x_q;
        y_d      = y_q;
        tvalid_d = tvalid_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d  = S_RUN;
                    tvalid_d = 1'b1;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d  = S_IDLE;
                    tvalid_d = 1'b0;
                    h_d      = '0;
                    v_d      = '0;
                    x_d      = XS;
                    y_d      = YS;
                end else if (ray_axis_tready) begin
                    if (at_eof) begin
                        // Counters always reload here so IDLE holds the frame origin.
                        done_d = 1'b1;
                        h_d    = '0;
                        v_d    = '0;
                        x_d    = XS;
                        y_d    = YS;
                        if (!continuous) begin
                            state_d  = S_IDLE;
                            tvalid_d = 1'b0;
                        end
                    end else if (at_eol) begin
                        h_d = '0;
                        x_d = XS;
                        v_d = v_q + VW'(1);
                        y_d = y_q + YST;
                    end else begin
                        h_d = h_q + HW'(1);
                        x_d = x_q + XST;
                    end
                end
            end
            default: begin
                state_d  = S_IDLE;
                tvalid_d = 1'b0;
            end
        endcase
        tlast_d = tvalid_d && (h_d == H_LAST);
        sof_d   = tvalid_d && (h_d == '0) && (v_d == '0);
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q  <= S_IDLE;
            h_q      <= '0;
            v_q      <= '0;
            x_q      <= XS;
            y_q      <= YS;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            sof_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            h_q      <= h_d;
            v_q      <= v_d;
            x_q      <= x_d;
            y_q      <= y_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            sof_q    <= sof_d;
            done_q   <= done_d;
        end
    end

    assign busy            = (state_q == S_RUN);
    assign frame_done      = done_q;
    assign ray_axis_tdata  = {x_q, y_q, ZD};
    assign ray_axis_tuser  = {sof_q, v_q, h_q};
    assign ray_axis_tlast  = tlast_q;
    assign ray_axis_tvalid = tvalid_q;

endmodule
